// File: rtl/cache_bus_pkg.sv
// Shared types and constants for the cache bus arbiter and its round-robin picker.
package cache_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IR   = 3'd1,
    ST_DW   = 3'd2,
    ST_DB   = 3'd3,
    ST_DR   = 3'd4
  } state_t;

  localparam logic GRANT_IC = 1'b0;
  localparam logic GRANT_DC = 1'b1;

  // Every burst moves one 128-bit line as two 64-bit beats.
  localparam int BURST_BEATS = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; purely combinational, the caller owns last_grant.
module rr_arb2
  import cache_bus_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) begin
      // On a tie the requester that did not win last time goes next.
      gnt_idx = ~last_grant;
    end else if (req1) begin
      gnt_idx = GRANT_DC;
    end else begin
      gnt_idx = GRANT_IC;
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one downstream burst port between icache refills and dcache write-back/refill.
// Handshake: a beat/response transfers on the cycle where its valid and ready are both high.
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_r_valid,
  input  logic [ADDR_W-1:0] ic_r_raddr,
  output logic [DATA_W-1:0] ic_r_rdata,
  output logic              ic_r_rlast,
  output logic              ic_r_ready,
  input  logic              dc_r_valid,
  input  logic [ADDR_W-1:0] dc_r_raddr,
  output logic [DATA_W-1:0] dc_r_rdata,
  output logic              dc_r_rlast,
  output logic              dc_r_ready,
  input  logic              dc_w_valid,
  input  logic [ADDR_W-1:0] dc_w_waddr,
  input  logic [DATA_W-1:0] dc_w_wdata,
  input  logic              dc_w_wlast,
  output logic              dc_w_ready,
  input  logic              dc_b_ready,
  output logic              dc_b_valid,
  output logic              mem_r_valid,
  output logic [ADDR_W-1:0] mem_r_raddr,
  input  logic [DATA_W-1:0] mem_r_rdata,
  input  logic              mem_r_rlast,
  input  logic              mem_r_ready,
  output logic              mem_w_valid,
  output logic [ADDR_W-1:0] mem_w_waddr,
  output logic [DATA_W-1:0] mem_w_wdata,
  output logic              mem_w_wlast,
  input  logic              mem_w_ready,
  output logic              mem_b_ready,
  input  logic              mem_b_valid,
  output logic [2:0]        dbg_state,
  output logic              dbg_last_grant
);

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                gnt_valid, gnt_idx;

  rr_arb2 u_arb (
    .req0       (ic_r_valid),
    .req1       (dc_w_valid | dc_r_valid),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign ic_r_rdata     = mem_r_rdata;
  assign dc_r_rdata     = mem_r_rdata;
  assign mem_r_raddr    = raddr_q;
  assign dbg_state      = state_q;
  assign dbg_last_grant = last_grant_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_DC;
      raddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      raddr_q      <= raddr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    raddr_d      = raddr_q;
    ic_r_ready   = 1'b0;
    ic_r_rlast   = 1'b0;
    dc_r_ready   = 1'b0;
    dc_r_rlast   = 1'b0;
    dc_w_ready   = 1'b0;
    dc_b_valid   = 1'b0;
    mem_r_valid  = 1'b0;
    mem_w_valid  = 1'b0;
    mem_w_waddr  = '0;
    mem_w_wdata  = '0;
    mem_w_wlast  = 1'b0;
    mem_b_ready  = 1'b0;
    // Outputs stay quiet while reset is held, even if the old state was mid-burst.
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            if (gnt_idx == GRANT_IC) begin
              raddr_d      = ic_r_raddr;
              last_grant_d = GRANT_IC;
              state_d      = ST_IR;
            end else begin
              last_grant_d = GRANT_DC;
              // A dirty line is written back before its refill is fetched.
              if (dc_w_valid) begin
                state_d = ST_DW;
              end else begin
                raddr_d = dc_r_raddr;
                state_d = ST_DR;
              end
            end
          end
        end
        ST_IR: begin
          mem_r_valid = 1'b1;
          ic_r_ready  = mem_r_ready;
          ic_r_rlast  = mem_r_ready & mem_r_rlast;
          if (mem_r_ready && mem_r_rlast) state_d = ST_IDLE;
        end
        ST_DR: begin
          mem_r_valid = 1'b1;
          dc_r_ready  = mem_r_ready;
          dc_r_rlast  = mem_r_ready & mem_r_rlast;
          if (mem_r_ready && mem_r_rlast) state_d = ST_IDLE;
        end
        ST_DW: begin
          mem_w_valid = dc_w_valid;
          mem_w_waddr = dc_w_waddr;
          mem_w_wdata = dc_w_wdata;
          mem_w_wlast = dc_w_wlast;
          dc_w_ready  = mem_w_ready;
          if (dc_w_valid && mem_w_ready && dc_w_wlast) state_d = ST_DB;
        end
        ST_DB: begin
          mem_b_ready = dc_b_ready;
          dc_b_valid  = mem_b_valid;
          if (mem_b_valid && dc_b_ready) begin
            // The refill follows directly without re-arbitrating against the icache.
            if (dc_r_valid) begin
              raddr_d = dc_r_raddr;
              state_d = ST_DR;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: driver pushes expected events, a negedge monitor pops and compares.
module tb_cache_bus_arbiter;
  import cache_bus_pkg::*;

  localparam int EW = 148;
  localparam logic [3:0] T_MREQ = 4'd1, T_IC = 4'd2, T_IC_L = 4'd3, T_DC = 4'd4,
                         T_DC_L = 4'd5, T_W = 4'd6, T_W_L = 4'd7, T_B = 4'd8;
  localparam logic [15:0] ANY = 16'hFFFF;

  logic        clock, reset;
  logic        ic_r_valid, ic_r_rlast, ic_r_ready;
  logic [63:0] ic_r_raddr, ic_r_rdata;
  logic        dc_r_valid, dc_r_rlast, dc_r_ready;
  logic [63:0] dc_r_raddr, dc_r_rdata;
  logic        dc_w_valid, dc_w_wlast, dc_w_ready, dc_b_ready, dc_b_valid;
  logic [63:0] dc_w_waddr, dc_w_wdata;
  logic        mem_r_valid, mem_r_rlast, mem_r_ready;
  logic [63:0] mem_r_raddr, mem_r_rdata;
  logic        mem_w_valid, mem_w_wlast, mem_w_ready, mem_b_ready, mem_b_valid;
  logic [63:0] mem_w_waddr, mem_w_wdata;
  logic [2:0]  dbg_state;
  logic        dbg_last_grant;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic prev_rv = 1'b0;
  logic [63:0] t4_addr[4];

  cache_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .ic_r_valid(ic_r_valid), .ic_r_raddr(ic_r_raddr), .ic_r_rdata(ic_r_rdata),
    .ic_r_rlast(ic_r_rlast), .ic_r_ready(ic_r_ready),
    .dc_r_valid(dc_r_valid), .dc_r_raddr(dc_r_raddr), .dc_r_rdata(dc_r_rdata),
    .dc_r_rlast(dc_r_rlast), .dc_r_ready(dc_r_ready),
    .dc_w_valid(dc_w_valid), .dc_w_waddr(dc_w_waddr), .dc_w_wdata(dc_w_wdata),
    .dc_w_wlast(dc_w_wlast), .dc_w_ready(dc_w_ready),
    .dc_b_ready(dc_b_ready), .dc_b_valid(dc_b_valid),
    .mem_r_valid(mem_r_valid), .mem_r_raddr(mem_r_raddr), .mem_r_rdata(mem_r_rdata),
    .mem_r_rlast(mem_r_rlast), .mem_r_ready(mem_r_ready),
    .mem_w_valid(mem_w_valid), .mem_w_waddr(mem_w_waddr), .mem_w_wdata(mem_w_wdata),
    .mem_w_wlast(mem_w_wlast), .mem_w_ready(mem_w_ready),
    .mem_b_ready(mem_b_ready), .mem_b_valid(mem_b_valid),
    .dbg_state(dbg_state), .dbg_last_grant(dbg_last_grant)
  );

  // Clock and cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Scoreboard helpers
  function automatic void push(input logic [3:0] tag, input int c, input logic [63:0] a,
                               input logic [63:0] d);
    logic [15:0] c16;
    c16 = (c < 0) ? ANY : c[15:0];
    exp_q.push_back({tag, c16, a, d});
  endfunction

  task automatic sb_pop(input logic [3:0] tag, input int c, input logic [63:0] a,
                        input logic [63:0] d, input string name);
    logic [EW-1:0] e;
    logic [15:0]   ec;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event tag=%0d a=%h d=%h, expected no event", name, tag, a, d);
    end else begin
      e  = exp_q.pop_front();
      ec = e[143:128];
      if (e[147:144] !== tag || e[127:64] !== a || e[63:0] !== d ||
          (ec !== ANY && ec !== c[15:0])) begin
        n_fail++;
        $display("FAIL %s: got tag=%0d cyc=%0d a=%h d=%h, expected tag=%0d cyc=%0d a=%h d=%h",
                 name, tag, c, a, d, e[147:144], ec, e[127:64], e[63:0]);
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    if (!reset) begin
      n_checks++;
      if (mem_r_valid && mem_w_valid) begin
        n_fail++;
        $display("FAIL rw_overlap: got mem_r_valid=1 mem_w_valid=1 expected not both");
      end
      if (mem_r_valid && !prev_rv) sb_pop(T_MREQ, cyc, mem_r_raddr, 64'd0, "mem_read_req");
      if (ic_r_ready) sb_pop(ic_r_rlast ? T_IC_L : T_IC, cyc, 64'd0, ic_r_rdata, "ic_beat");
      if (dc_r_ready) sb_pop(dc_r_rlast ? T_DC_L : T_DC, cyc, 64'd0, dc_r_rdata, "dc_beat");
      if (ic_r_rlast && !ic_r_ready) sb_pop(T_IC_L, cyc, 64'd0, 64'd0, "ic_rlast_unqualified");
      if (dc_r_rlast && !dc_r_ready) sb_pop(T_DC_L, cyc, 64'd0, 64'd0, "dc_rlast_unqualified");
      if (mem_w_valid && mem_w_ready)
        sb_pop(mem_w_wlast ? T_W_L : T_W, cyc, mem_w_waddr, mem_w_wdata, "mem_write_beat");
      if (dc_b_valid && dc_b_ready) sb_pop(T_B, cyc, 64'd0, 64'd0, "dc_b_resp");
    end
    prev_rv = reset ? 1'b0 : mem_r_valid;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_mem_r();
    int i;
    i = 0;
    while (!mem_r_valid && i < 40) begin
      tick();
      i++;
    end
    if (!mem_r_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_mem_r: got no mem_r_valid in 40 cycles expected a read request");
    end
  endtask

  task automatic read_burst(input logic [63:0] a, input logic [63:0] b);
    mem_r_ready = 1'b1;
    mem_r_rdata = a;
    mem_r_rlast = 1'b0;
    tick();
    mem_r_rdata = b;
    mem_r_rlast = 1'b1;
    tick();
    mem_r_ready = 1'b0;
    mem_r_rlast = 1'b0;
    mem_r_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    ic_r_valid  = 1'b0; ic_r_raddr = '0;
    dc_r_valid  = 1'b0; dc_r_raddr = '0;
    dc_w_valid  = 1'b0; dc_w_waddr = '0; dc_w_wdata = '0; dc_w_wlast = 1'b0;
    dc_b_ready  = 1'b0;
    mem_r_ready = 1'b0; mem_r_rlast = 1'b0; mem_r_rdata = 64'h1234_5678_9ABC_DEF0;
    mem_w_ready = 1'b0; mem_b_valid = 1'b0;
    tick();
    chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("reset_last_grant", 64'(dbg_last_grant), 64'd1);
    chk("reset_raddr_q", mem_r_raddr, 64'd0);
    chk("reset_outputs", 64'({mem_r_valid, mem_w_valid, mem_b_ready, mem_w_wlast, ic_r_ready,
                              ic_r_rlast, dc_r_ready, dc_r_rlast, dc_w_ready, dc_b_valid}), 64'd0);
    chk("reset_ic_rdata_pass", ic_r_rdata, 64'h1234_5678_9ABC_DEF0);
    chk("reset_dc_rdata_pass", dc_r_rdata, 64'h1234_5678_9ABC_DEF0);
    reset       = 1'b0;
    mem_r_rdata = '0;
  endtask

  initial begin
    int n;
    do_reset();

    // Lone icache read
    n = cyc;
    push(T_MREQ, n + 1, 64'h8000_0040, 64'd0);
    push(T_IC, -1, 64'd0, 64'hAAAA_0000_0000_0001);
    push(T_IC_L, -1, 64'd0, 64'hBBBB_0000_0000_0002);
    ic_r_valid = 1'b1;
    ic_r_raddr = 64'h8000_0040;
    tick();
    wait_mem_r();
    read_burst(64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002);
    ic_r_valid = 1'b0;
    chk("t1_back_to_idle", 64'(dbg_state), 64'(ST_IDLE));
    chk("t1_last_grant_ic", 64'(dbg_last_grant), 64'd0);

    // Simultaneous requests after reset: icache first, dcache the cycle after IDLE
    do_reset();
    n = cyc;
    push(T_MREQ, n + 1, 64'h8000_0080, 64'd0);
    push(T_IC, -1, 64'd0, 64'h1100_0000_0000_0001);
    push(T_IC_L, -1, 64'd0, 64'h1100_0000_0000_0002);
    push(T_MREQ, n + 4, 64'h8000_00C0, 64'd0);
    push(T_DC, -1, 64'd0, 64'h2200_0000_0000_0001);
    push(T_DC_L, -1, 64'd0, 64'h2200_0000_0000_0002);
    ic_r_valid = 1'b1; ic_r_raddr = 64'h8000_0080;
    dc_r_valid = 1'b1; dc_r_raddr = 64'h8000_00C0;
    tick();
    wait_mem_r();
    read_burst(64'h1100_0000_0000_0001, 64'h1100_0000_0000_0002);
    ic_r_valid = 1'b0;
    wait_mem_r();
    read_burst(64'h2200_0000_0000_0001, 64'h2200_0000_0000_0002);
    dc_r_valid = 1'b0;

    // Dirty eviction: write-back, B response, then refill straight from DB
    n = cyc;
    push(T_W, -1, 64'h8000_1000, 64'hD0D0_0000_0000_0000);
    push(T_W_L, -1, 64'h8000_1000, 64'hD0D0_0000_0000_0001);
    push(T_B, n + 6, 64'd0, 64'd0);
    push(T_MREQ, n + 7, 64'h8000_2000, 64'd0);
    push(T_DC, -1, 64'd0, 64'h3300_0000_0000_0001);
    push(T_DC_L, -1, 64'd0, 64'h3300_0000_0000_0002);
    dc_w_valid = 1'b1; dc_w_waddr = 64'h8000_1000;
    dc_w_wdata = 64'hD0D0_0000_0000_0000; dc_w_wlast = 1'b0;
    dc_r_valid = 1'b1; dc_r_raddr = 64'h8000_2000;
    mem_w_ready = 1'b1; dc_b_ready = 1'b1;
    tick();
    tick();
    dc_w_wdata = 64'hD0D0_0000_0000_0001; dc_w_wlast = 1'b1;
    tick();
    dc_w_valid = 1'b0; dc_w_wlast = 1'b0; dc_w_wdata = '0;
    chk("t3_in_db", 64'(dbg_state), 64'(ST_DB));
    tick();
    tick();
    tick();
    mem_b_valid = 1'b1;
    tick();
    mem_b_valid = 1'b0;
    chk("t3_db_to_dr", 64'(dbg_state), 64'(ST_DR));
    wait_mem_r();
    read_burst(64'h3300_0000_0000_0001, 64'h3300_0000_0000_0002);
    dc_r_valid = 1'b0;

    // Fairness: both continuously requesting alternate IC, DC, IC, DC
    t4_addr[0] = 64'h8000_3000; t4_addr[1] = 64'h8000_4000;
    t4_addr[2] = 64'h8000_3040; t4_addr[3] = 64'h8000_4040;
    n = cyc;
    for (int k = 0; k < 4; k++) begin
      push(T_MREQ, n + 1 + 3 * k, t4_addr[k], 64'd0);
      push((k % 2 == 0) ? T_IC : T_DC, -1, 64'd0, 64'hF000_0000_0000_0000 + 64'(2 * k));
      push((k % 2 == 0) ? T_IC_L : T_DC_L, -1, 64'd0, 64'hF000_0000_0000_0001 + 64'(2 * k));
    end
    ic_r_valid = 1'b1; ic_r_raddr = t4_addr[0];
    dc_r_valid = 1'b1; dc_r_raddr = t4_addr[1];
    tick();
    for (int k = 0; k < 4; k++) begin
      wait_mem_r();
      read_burst(64'hF000_0000_0000_0000 + 64'(2 * k), 64'hF000_0000_0000_0001 + 64'(2 * k));
      if (k == 0) ic_r_raddr = t4_addr[2];
      if (k == 1) dc_r_raddr = t4_addr[3];
      if (k == 3) begin
        ic_r_valid = 1'b0;
        dc_r_valid = 1'b0;
      end
    end

    // Write-ready backpressure on the wlast beat, with an early B held off until DB
    n = cyc;
    push(T_W, -1, 64'h8000_5000, 64'h5500_0000_0000_0000);
    push(T_W_L, -1, 64'h8000_5000, 64'h5500_0000_0000_0001);
    push(T_B, n + 7, 64'd0, 64'd0);
    dc_w_valid = 1'b1; dc_w_waddr = 64'h8000_5000;
    dc_w_wdata = 64'h5500_0000_0000_0000; dc_w_wlast = 1'b0;
    mem_w_ready = 1'b1; dc_b_ready = 1'b1;
    tick();
    tick();
    dc_w_wdata = 64'h5500_0000_0000_0001; dc_w_wlast = 1'b1;
    mem_w_ready = 1'b0; mem_b_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t5_hold_state", 64'(dbg_state), 64'(ST_DW));
      chk("t5_hold_wdata", mem_w_wdata, 64'h5500_0000_0000_0001);
      chk("t5_hold_wlast", 64'(mem_w_wlast), 64'd1);
      chk("t5_no_early_b", 64'({dc_b_valid, mem_b_ready, dc_w_ready}), 64'd0);
      tick();
    end
    mem_w_ready = 1'b1;
    tick();
    dc_w_valid = 1'b0; dc_w_wlast = 1'b0;
    tick();
    mem_b_valid = 1'b0;
    chk("t5_back_to_idle", 64'(dbg_state), 64'(ST_IDLE));

    // Reset in the middle of a dcache read
    n = cyc;
    push(T_MREQ, n + 1, 64'h8000_6000, 64'd0);
    push(T_DC, -1, 64'd0, 64'h6600_0000_0000_0001);
    dc_r_valid = 1'b1; dc_r_raddr = 64'h8000_6000;
    tick();
    wait_mem_r();
    mem_r_ready = 1'b1; mem_r_rdata = 64'h6600_0000_0000_0001; mem_r_rlast = 1'b0;
    tick();
    chk("t6_mid_dr", 64'(dbg_state), 64'(ST_DR));
    do_reset();

    tick();
    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Shares one downstream memory burst port between the instruction cache (read refills only) and the data cache (write-back plus read refill).
- Runs one transaction at a time on the downstream port.
- A data-cache write-back is always finished, including its B response, before that cache's refill read is issued.
- Sits between the two caches' cache_bus ports and the memory/AXI bridge.

Parameters:
- ADDR_W, 64, width of all bus addresses.
- DATA_W, 64, width of one burst beat; all bursts are 2 beats (one 128-bit line).

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ic_r_valid  in  1  icache refill request, held until its rlast beat.
- ic_r_raddr  in  ADDR_W  icache line address.
- ic_r_rdata  out  DATA_W  refill beat data.
- ic_r_rlast  out  1  last refill beat (qualified).
- ic_r_ready  out  1  refill beat valid this cycle.
- dc_r_valid  in  1  dcache refill request.
- dc_r_raddr  in  ADDR_W  dcache line address.
- dc_r_rdata  out  DATA_W  refill beat data.
- dc_r_rlast  out  1  last refill beat (qualified).
- dc_r_ready  out  1  refill beat valid.
- dc_w_valid  in  1  write-back beat valid.
- dc_w_waddr  in  ADDR_W  write-back line address.
- dc_w_wdata  in  DATA_W  write-back beat data.
- dc_w_wlast  in  1  last write-back beat.
- dc_w_ready  out  1  write beat accepted.
- dc_b_ready  in  1  dcache ready for write response.
- dc_b_valid  out  1  write response.
- mem_r_valid  out  1  downstream read request.
- mem_r_raddr  out  ADDR_W  downstream read address.
- mem_r_rdata  in  DATA_W  read beat data.
- mem_r_rlast  in  1  last read beat.
- mem_r_ready  in  1  read beat valid.
- mem_w_valid  out  1  downstream write beat valid.
- mem_w_waddr  out  ADDR_W  write address.
- mem_w_wdata  out  DATA_W  write data.
- mem_w_wlast  out  1  last write beat.
- mem_w_ready  in  1  write beat accepted.
- mem_b_ready  out  1  ready for write response.
- mem_b_valid  in  1  write response.

Behaviour:
- States:
  - IDLE
  - IR: icache read.
  - DW: dcache write beats.
  - DB: dcache write response.
  - DR: dcache read.
- Registers: state, last_grant (0 = icache, 1 = dcache), raddr_q.
- Reset state: state=IDLE, last_grant=1 (icache wins the first tie), raddr_q=0.
- Reset values of outputs: every valid, ready, last and b output is 0. The rdata outputs carry mem_r_rdata combinationally at all times, including during reset.

IDLE:
- ic_req = ic_r_valid; dc_req = dc_w_valid | dc_r_valid.
- If exactly one requests, grant it. If both request, grant the one that is not last_grant (round-robin).
- Grant to icache: raddr_q<=ic_r_raddr, last_grant<=0, go to IR.
- Grant to dcache: last_grant<=1. If dc_w_valid, go to DW (write-back goes first, even when dc_r_valid is also high). Otherwise raddr_q<=dc_r_raddr and go to DR.
- Grant takes 1 cycle: the downstream request appears the cycle after the request is seen.
- All downstream valids are 0 in IDLE.

IR / DR:
- mem_r_valid=1 and mem_r_raddr=raddr_q for the whole state.
- The granted master's r_ready = mem_r_ready. The granted master's r_rlast = mem_r_ready & mem_r_rlast.
- The non-granted master sees r_ready=0 and r_rlast=0 always.
- On mem_r_ready & mem_r_rlast, go to IDLE.
- Beats before rlast are forwarded as-is, with no beat counter.

DW:
- mem_w_* = dc_w_*; dc_w_ready = mem_w_ready.
- On mem_w_valid & mem_w_ready & dc_w_wlast, go to DB.
- dc_b_valid and mem_b_ready are held 0 in DW. A B response that arrives early is not accepted until DB.

DB:
- mem_b_ready = dc_b_ready; dc_b_valid = mem_b_valid; mem_w_valid=0.
- On B fire: if dc_r_valid, set raddr_q<=dc_r_raddr and go straight to DR. The refill is not re-arbitrated against the icache. Otherwise go to IDLE.

Other rules:
- The master's valid is ignored once granted. A request withdrawn mid-burst is a master protocol violation; the arbiter still completes on rlast or B.
- The mem read and write channels are never active in the same cycle.
- Reset mid-burst: return to IDLE immediately and abandon the outstanding transaction. The memory model must be reset in the same cycle.
- No timeout. A hung downstream burst holds the port indefinitely.

Decomposition:
- Package cache_bus_pkg holds:
  - State encodings ST_IDLE=3'd0, ST_IR=3'd1, ST_DW=3'd2, ST_DB=3'd3, ST_DR=3'd4.
  - GRANT_IC=1'b0, GRANT_DC=1'b1.
  - BURST_BEATS=2.
- Sub-module rr_arb2: a 2-way round-robin picker taking (req0, req1, last_grant) and returning (gnt_valid, gnt_idx). It is combinational; the FSM owns the last_grant register.

Test Plan:
- Lone icache read: ic_r_valid=1, raddr=0x8000_0040; mem returns 2 beats, A then B with rlast.
  -> mem_r_raddr=0x8000_0040 from cycle+1; ic sees ready on both beats and rlast only on beat B; state back to IDLE.
- Simultaneous requests after reset: ic and dc reads both high in the same cycle.
  -> icache is served first; dcache read is issued the cycle after IDLE is re-entered; dc_r_rlast stays 0 during the icache burst.
- Dirty eviction: dc_w_valid and dc_r_valid both high; waddr=0x8000_1000, raddr=0x8000_2000; mem_b_valid 3 cycles after wlast.
  -> 2 write beats, then B forwarded to the dcache, then DR with raddr 0x8000_2000; mem_r_valid never overlaps mem_w_valid.
- Fairness: icache issues back-to-back requests while the dcache is continuously pending.
  -> grants alternate IC, DC, IC, DC.
- Write-ready backpressure: mem_w_ready low for 4 cycles on beat 1.
  -> wdata and wlast held stable; no state advance until the wlast beat fires.
- Reset asserted in the middle of DR.
  -> next cycle state=IDLE, all valid/ready outputs 0, last_grant=1.
